// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if -- bus bundle for the reg_file_mp multi-port register file.
//
// Signals (master = requester, e.g. the CPU decode stage; slave = reg_file_mp):
//   wen   [NWRITE]          per-port write enable
//   wsel  [NWRITE*AW]       per-port write address, port i at [i*AW +: AW]
//   wdat  [NWRITE*DATA_W]   per-port write data,    port i at [i*DATA_W +: DATA_W]
//   rsel  [NREAD*AW]        per-port read address
//   rdat  [NREAD*DATA_W]    per-port read data, combinational from rsel
//   clr                     one-cycle pulse that starts a scrub
//   busy                    high while a scrub is in progress
interface reg_file_mp_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned NREAD  = 2,
   parameter int unsigned NWRITE = 1
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [NWRITE-1:0]        wen;
   logic [NWRITE*AW-1:0]     wsel;
   logic [NWRITE*DATA_W-1:0] wdat;
   logic [NREAD*AW-1:0]      rsel;
   logic [NREAD*DATA_W-1:0]  rdat;
   logic                     clr;
   logic                     busy;

   modport master (
      output wen, wsel, wdat, rsel, clr,
      input  rdat, busy
   );

   modport slave (
      input  wen, wsel, wdat, rsel, clr,
      output rdat, busy
   );
endinterface

// File: rtl/reg_file_mp.sv
// reg_file_mp -- parametrised multi-port register file with scrub engine.
//
// Storage has no per-bit reset; instead a scrub engine writes zero to one
// entry per cycle, DEPTH cycles in total, after RST or on a clr pulse.
// While scrubbing, writes are ignored and every read port returns 0.
//
// Ports:
//   CLK  in   clock, all state changes on the rising edge
//   RST  in   synchronous active-high reset; (re)starts a full scrub
//   bus  slave modport of reg_file_mp_if (wen/wsel/wdat/rsel/rdat/clr/busy)
//
// Optional feature macro: RF_BYPASS_EN -- when defined, a same-cycle write
// to a valid, writable address is forwarded to matching read ports.
module reg_file_mp #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned NREAD    = 2,
   parameter int unsigned NWRITE   = 1,
   parameter int unsigned ZERO_REG = 1
) (
   input logic          CLK,
   input logic          RST,
   reg_file_mp_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic {
      S_IDLE,
      S_SCRUB
   } state_e;

   state_e                  state_q;
   logic                    busy_q;
   logic [AW-1:0]           cnt_q;
   logic [DATA_W-1:0]       mem_q [DEPTH];
   logic [NREAD*DATA_W-1:0] rdat_d;

   // Address is in range and not the hard-wired zero entry.
   function automatic logic live(input logic [AW-1:0] a);
      live = (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   // Scrub FSM; busy is registered alongside the state.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_SCRUB;
         busy_q  <= 1'b1;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.clr) begin
                  state_q <= S_SCRUB;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            S_SCRUB: begin
               if (cnt_q == AW'(DEPTH - 1)) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + AW'(1);
               end
            end
            default: begin
               state_q <= S_SCRUB;
               busy_q  <= 1'b1;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // Storage. Ports are visited in ascending order so the highest-index
   // port writing a given address takes effect.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         if (state_q == S_SCRUB) begin
            mem_q[cnt_q] <= '0;
         end else begin
            for (int unsigned i = 0; i < NWRITE; i++) begin
               if (bus.wen[i] && live(bus.wsel[i*AW +: AW])) begin
                  mem_q[bus.wsel[i*AW +: AW]] <= bus.wdat[i*DATA_W +: DATA_W];
               end
            end
         end
      end
   end

   // Combinational read ports.
   always_comb begin
      logic [AW-1:0] ra;
      rdat_d = '0;
      ra     = '0;
      for (int unsigned j = 0; j < NREAD; j++) begin
         ra = bus.rsel[j*AW +: AW];
         if ((state_q == S_IDLE) && live(ra)) begin
            rdat_d[j*DATA_W +: DATA_W] = mem_q[ra];
`ifdef RF_BYPASS_EN
            for (int unsigned i = 0; i < NWRITE; i++) begin
               if (bus.wen[i] && (bus.wsel[i*AW +: AW] == ra)) begin
                  rdat_d[j*DATA_W +: DATA_W] = bus.wdat[i*DATA_W +: DATA_W];
               end
            end
`endif
         end
      end
   end

   assign bus.rdat = rdat_d;
   assign bus.busy = busy_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp -- self-checking bench for reg_file_mp.
// Instance A: DEPTH=32, NREAD=2, NWRITE=2, ZERO_REG=1.
// Instance B: DEPTH=24, NREAD=1, NWRITE=1, ZERO_REG=0 (out-of-range cases).
// Expected bypass behaviour follows RF_BYPASS_EN as seen by this file.
module tb_reg_file_mp;
   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   int unsigned total = 0;
   int unsigned bad   = 0;

   reg_file_mp_if #(.DATA_W(32), .DEPTH(32), .NREAD(2), .NWRITE(2)) ifa ();
   reg_file_mp_if #(.DATA_W(32), .DEPTH(24), .NREAD(1), .NWRITE(1)) ifb ();

   reg_file_mp #(.DATA_W(32), .DEPTH(32), .NREAD(2), .NWRITE(2), .ZERO_REG(1))
      dut_a (.CLK(CLK), .RST(RST), .bus(ifa.slave));
   reg_file_mp #(.DATA_W(32), .DEPTH(24), .NREAD(1), .NWRITE(1), .ZERO_REG(0))
      dut_b (.CLK(CLK), .RST(RST), .bus(ifb.slave));

   typedef struct {
      logic [1:0]  wen;
      logic [4:0]  ws0, ws1;
      logic [31:0] wd0, wd1;
      logic [4:0]  rs0, rs1;
      logic [31:0] e0, e1;
   } vec_t;

   vec_t        tbl [10];
   int          ea, eb, e;
   logic        zero_ok;
   logic [31:0] byp_exp;
   logic [31:0] exp_b;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Vectors applied in IDLE; reads are checked before the edge that commits writes.
      tbl[0] = '{2'b01, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        5'd6,  5'd0,  32'h0,        32'h0};
      tbl[1] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd5,  5'd6,  32'hDEADBEEF, 32'h0};
      tbl[2] = '{2'b01, 5'd0,  5'd0,  32'h12345678, 32'h0,        5'd5,  5'd1,  32'hDEADBEEF, 32'h0};
      tbl[3] = '{2'b11, 5'd7,  5'd7,  32'h11,       32'h22,       5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
      tbl[4] = '{2'b11, 5'd9,  5'd10, 32'hCAFEF00D, 32'h0BADC0DE, 5'd7,  5'd0,  32'h22,       32'h0};
      tbl[5] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd9,  5'd10, 32'hCAFEF00D, 32'h0BADC0DE};
      tbl[6] = '{2'b10, 5'd0,  5'd5,  32'h0,        32'h55AA55AA, 5'd7,  5'd9,  32'h22,       32'hCAFEF00D};
      tbl[7] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd5,  5'd31, 32'h55AA55AA, 32'h0};
      tbl[8] = '{2'b01, 5'd31, 5'd0,  32'hFFFFFFFF, 32'h0,        5'd10, 5'd1,  32'h0BADC0DE, 32'h0};
      tbl[9] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd31, 5'd0,  32'hFFFFFFFF, 32'h0};

`ifdef RF_BYPASS_EN
      byp_exp = 32'hA5A5A5A5;
`else
      byp_exp = 32'h0;
`endif

      RST      = 1'b1;
      ifa.wen  = '0; ifa.wsel = '0; ifa.wdat = '0; ifa.rsel = {5'd6, 5'd5}; ifa.clr = 1'b0;
      ifb.wen  = '0; ifb.wsel = '0; ifb.wdat = '0; ifb.rsel = 5'd3;         ifb.clr = 1'b0;

      // Reset: busy and zero reads from the first edge with RST high.
      tick();
      chk("rst_busy_a", 32'(ifa.busy), 32'd1);
      chk("rst_rdat_a", ifa.rdat[31:0], 32'h0);
      chk("rst_busy_b", 32'(ifb.busy), 32'd1);
      tick();
      RST = 1'b0;

      ea = 0; eb = 0; zero_ok = 1'b1;
      for (int n = 1; n <= 100; n++) begin
         tick();
         if (ifa.busy === 1'b1 && ifa.rdat !== 64'h0) zero_ok = 1'b0;
         if (ea == 0 && ifa.busy === 1'b0) ea = n;
         if (eb == 0 && ifb.busy === 1'b0) eb = n;
         if (ea != 0 && eb != 0) break;
      end
      chk("scrub_len_a", 32'(ea), 32'd32);
      chk("scrub_len_b", 32'(eb), 32'd24);
      chk("scrub_rdat_zero", 32'(zero_ok), 32'd1);

      for (int k = 0; k < 32; k++) begin
         ifa.rsel = {5'd0, 5'(k)};
         #1;
         chk($sformatf("after_scrub_a[%0d]", k), ifa.rdat[31:0], 32'h0);
      end

      // Table-driven read/write vectors.
      for (int k = 0; k < 10; k++) begin
         ifa.wen  = tbl[k].wen;
         ifa.wsel = {tbl[k].ws1, tbl[k].ws0};
         ifa.wdat = {tbl[k].wd1, tbl[k].wd0};
         ifa.rsel = {tbl[k].rs1, tbl[k].rs0};
         #1;
         chk($sformatf("vec%0d_rd0", k), ifa.rdat[31:0],  tbl[k].e0);
         chk($sformatf("vec%0d_rd1", k), ifa.rdat[63:32], tbl[k].e1);
         tick();
      end
      ifa.wen = '0;

      // Same-cycle write/read on port 1.
      ifa.wen  = 2'b01;
      ifa.wsel = {5'd0, 5'd3};
      ifa.wdat = {32'h0, 32'hA5A5A5A5};
      ifa.rsel = {5'd3, 5'd3};
      #1;
      chk("bypass_same_cycle", ifa.rdat[63:32], byp_exp);
      tick();
      ifa.wen = '0;
      #1;
      chk("bypass_next_cycle", ifa.rdat[63:32], 32'hA5A5A5A5);

      // Entry 0 is never forwarded nor stored.
      ifa.wen  = 2'b01;
      ifa.wsel = {5'd0, 5'd0};
      ifa.wdat = {32'h0, 32'h00000001};
      ifa.rsel = {5'd0, 5'd0};
      #1;
      chk("zero_reg_same_cycle", ifa.rdat[63:32], 32'h0);
      tick();
      ifa.wen = '0;
      #1;
      chk("zero_reg_after", ifa.rdat[63:32], 32'h0);

      // Write + clr in the same IDLE cycle, clr and wen during scrub.
      ifa.wen  = 2'b01;
      ifa.wsel = {5'd0, 5'd12};
      ifa.wdat = {32'h0, 32'h00001234};
      ifa.clr  = 1'b1;
      ifa.rsel = {5'd9, 5'd12};
      tick();
      ifa.wen = '0;
      ifa.clr = 1'b0;
      #1;
      chk("clr_busy", 32'(ifa.busy), 32'd1);
      chk("clr_rdat_busy", ifa.rdat[63:32], 32'h0);
      e = 0; zero_ok = 1'b1;
      for (int n = 1; n <= 100; n++) begin
         ifa.clr = (n == 10);
         ifa.wen = (n >= 20 && n <= 22) ? 2'b01 : 2'b00;
         ifa.wdat = {32'h0, 32'h00000077};
         tick();
         if (ifa.busy === 1'b1 && ifa.rdat !== 64'h0) zero_ok = 1'b0;
         if (ifa.busy === 1'b0) begin
            e = n;
            break;
         end
      end
      ifa.clr = 1'b0;
      ifa.wen = '0;
      chk("clr_scrub_len", 32'(e), 32'd32);
      chk("clr_scrub_rdat_zero", 32'(zero_ok), 32'd1);
      ifa.rsel = {5'd9, 5'd12};
      #1;
      chk("clr_entry12", ifa.rdat[31:0],  32'h0);
      chk("clr_entry9",  ifa.rdat[63:32], 32'h0);
      ifa.rsel = {5'd31, 5'd5};
      #1;
      chk("clr_entry5",  ifa.rdat[31:0],  32'h0);
      chk("clr_entry31", ifa.rdat[63:32], 32'h0);

      // RST in the middle of a scrub restarts it.
      ifa.wen  = 2'b01;
      ifa.wsel = {5'd0, 5'd4};
      ifa.wdat = {32'h0, 32'h44444444};
      tick();
      ifa.wen = '0;
      ifa.clr = 1'b1;
      tick();
      ifa.clr = 1'b0;
      for (int n = 1; n < 10; n++) tick();
      RST = 1'b1;
      tick();
      chk("rst_mid_busy", 32'(ifa.busy), 32'd1);
      RST = 1'b0;
      ea = 0; eb = 0;
      for (int n = 1; n <= 100; n++) begin
         tick();
         if (ea == 0 && ifa.busy === 1'b0) ea = n;
         if (eb == 0 && ifb.busy === 1'b0) eb = n;
         if (ea != 0 && eb != 0) break;
      end
      chk("rst_mid_len_a", 32'(ea), 32'd32);
      chk("rst_mid_len_b", 32'(eb), 32'd24);
      ifa.rsel = {5'd0, 5'd4};
      #1;
      chk("rst_mid_entry4", ifa.rdat[31:0], 32'h0);

      // Instance B: ordinary entry 0 and out-of-range addresses.
      ifb.wen  = 1'b1;
      ifb.wsel = 5'd0;
      ifb.wdat = 32'h00000013;
      tick();
      ifb.wsel = 5'd30;
      ifb.wdat = 32'hEEEEEEEE;
      ifb.rsel = 5'd0;
      #1;
      chk("b_entry0", ifb.rdat, 32'h00000013);
      tick();
      ifb.wsel = 5'd23;
      ifb.wdat = 32'h00002323;
      tick();
      ifb.wen  = 1'b0;
      ifb.rsel = 5'd30;
      #1;
      chk("b_rsel_oob", ifb.rdat, 32'h0);
      for (int k = 0; k < 24; k++) begin
         ifb.rsel = 5'(k);
         exp_b = (k == 0) ? 32'h00000013 : (k == 23) ? 32'h00002323 : 32'h0;
         #1;
         chk($sformatf("b_entry[%0d]", k), ifb.rdat, exp_b);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
